oflow_history_mem_ctrl: RTL and testbench
=========================================

# oflow_history_mem_ctrl

Parametrised history-frame memory controller for the optical-flow datapath. It owns a single-clock memory of DEPTH words and partitions it at run time into N equal regions, one per history frame. It rotates the write region on every frame boundary and serves two independent read ports addressed by frame age and offset. It supersedes the fixed 5-frame, combinational-pointer buffer: the pointer table is computed sequentially, frame rotation is internal, and ports use valid/ready.

## Interface
- DATA_WIDTH, 64, word width
- DEPTH, 128, total words in memory
- MAX_HISTORY, 5, maximum number of history regions
- ADDR_WIDTH, $clog2(DEPTH), memory address / offset width
- HIST_WIDTH, $clog2(MAX_HISTORY+1), width of N and age fields
- clk  in  1  clock, all logic on rising edge
- reset_N  in  1  reset, synchronous, active-low
- cfg_valid  in  1  load num_of_history_frames, start pointer computation
- num_of_history_frames  in  HIST_WIDTH  N, legal 1..MAX_HISTORY
- cfg_busy  out  1  pointer computation in progress
- cfg_err  out  1  one-cycle pulse: illegal N requested
- frame_start  in  1  pulse: close current frame, open next
- wr_valid  in  1  write request
- wr_ready  out  1  write accepted when wr_valid & wr_ready
- wr_offset  in  ADDR_WIDTH  word offset inside current region
- wr_data  in  DATA_WIDTH  write data
- rd_valid_0 / rd_valid_1  in  1  read request per port
- rd_age_0 / rd_age_1  in  HIST_WIDTH  0 = current frame, h = h frames ago
- rd_offset_0 / rd_offset_1  in  ADDR_WIDTH  word offset inside region
- rd_data_0 / rd_data_1  out  DATA_WIDTH  read data
- rd_data_valid_0 / rd_data_valid_1  out  1  rd_data qualifier
- rd_err_0 / rd_err_1  out  1  request rejected, aligned with rd_data_valid
- ovf_err  out  1  sticky: a write offset ≥ region size was dropped

## Operation
- States: UNCFG, CALC_DIV, CALC_BASE, RUN. Reset enters UNCFG.
- cfg_valid with N in 1..MAX_HISTORY, from any state: latch N, region=0, rem=DEPTH, go CALC_DIV, clear write_slot and frames_done. Illegal N: pulse cfg_err, state unchanged.
- CALC_DIV: each cycle, if rem ≥ N then rem -= N, region += 1; else go CALC_BASE. Region = floor(DEPTH/N); leftover words unused.
- CALC_BASE: base[i] = i*region written one entry per cycle, i = 0..N-1, via running accumulator (no multiplier). Then go RUN.
- cfg_busy = 1 in CALC_DIV and CALC_BASE. wr_ready = 1 only in RUN.
- Write: address = base[write_slot] + wr_offset. wr_offset ≥ region: write dropped, ovf_err set, cleared only by reset or cfg_valid.
- frame_start in RUN: write_slot = (write_slot+1) mod N; frames_done saturates at N-1. A write in the same cycle goes to the old slot. frame_start outside RUN is ignored.
- Read port k: slot = (write_slot − rd_age_k) mod N. Reject (rd_err_k) if not RUN, rd_age_k ≥ N, rd_age_k > frames_done, or rd_offset_k ≥ region.
- Same cycle, same address, write and read: read returns the old data. See Configuration.
- Ports 0 and 1 are fully independent. Both may target the same address.

## Timing
- Reset values: cfg_busy 0, cfg_err 0, wr_ready 0, rd_data_* 0, rd_data_valid_* 0, rd_err_* 0, ovf_err 0. Memory contents are not reset.
- Read latency is 1 cycle. rd_data_valid_k or rd_err_k is asserted in the cycle after rd_valid_k, never both. rd_data_k holds its value when not valid.
- cfg_busy duration is floor(DEPTH/N)+1+N cycles, starting the cycle after cfg_valid. Examples: DEPTH=128, N=5 gives 31 cycles; N=4 gives 37; N=1 gives 130.
- cfg_valid during CALC_* restarts the computation. reset_N low at any point returns the block to UNCFG in the next cycle.

## Configuration
- OFLOW_HIST_BYPASS_EN defined: a write and a read to the same address in the same cycle return the new wr_data (forwarding).
- OFLOW_HIST_BYPASS_EN undefined: the read returns the old data. No forwarding logic is built.

## Test plan
- Reset, then cfg N=5, DEPTH=128: cfg_busy high for exactly 31 cycles; base = {0,25,50,75,100}; wr_ready rises in the cycle after.
- N=5: write 0xA0+f at offset 3 in frames f=0..5 with frame_start between frames. In frame 5, read ages 0..4 at offset 3: 0xA5, 0xA4, 0xA3, 0xA2, 0xA1, each 1 cycle later. Age 5 returns rd_err.
- After a single frame_start, read age 2: rd_err=1, rd_data_valid=0. Read age 1: valid.
- N=4: write offset 32 → dropped, ovf_err=1; memory at base+32 unchanged. Reads at offset 31 succeed.
- Write 0x55 and read port 0 at the same address in the same cycle, old value 0x11: returns 0x11 without the macro, 0x55 with it. Port 1 reads the same address concurrently with identical result.
- cfg N=0 → cfg_err pulse, state stays RUN. cfg N=3 mid-CALC_DIV → restart, busy = 42+1+3 = 46 cycles, frames_done=0.

Source files
------------

// File: rtl/oflow_history_mem_ctrl.sv
// History-frame memory controller: one RAM split at run time into N rotating frame regions,
// one write port and two age/offset read ports. Define OFLOW_HIST_BYPASS_EN for write-to-read forwarding.
module oflow_history_mem_ctrl #(
  parameter int DATA_WIDTH  = 64,
  parameter int DEPTH       = 128,
  parameter int MAX_HISTORY = 5,
  parameter int ADDR_WIDTH  = $clog2(DEPTH),
  parameter int HIST_WIDTH  = $clog2(MAX_HISTORY + 1)
) (
  input  logic                  clk,
  input  logic                  reset_N,
  input  logic                  cfg_valid,
  input  logic [HIST_WIDTH-1:0] num_of_history_frames,
  output logic                  cfg_busy,
  output logic                  cfg_err,
  input  logic                  frame_start,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [ADDR_WIDTH-1:0] wr_offset,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_valid_0,
  input  logic                  rd_valid_1,
  input  logic [HIST_WIDTH-1:0] rd_age_0,
  input  logic [HIST_WIDTH-1:0] rd_age_1,
  input  logic [ADDR_WIDTH-1:0] rd_offset_0,
  input  logic [ADDR_WIDTH-1:0] rd_offset_1,
  output logic [DATA_WIDTH-1:0] rd_data_0,
  output logic [DATA_WIDTH-1:0] rd_data_1,
  output logic                  rd_data_valid_0,
  output logic                  rd_data_valid_1,
  output logic                  rd_err_0,
  output logic                  rd_err_1,
  output logic                  ovf_err
);

  // Region size can equal DEPTH (N=1), so it needs one bit more than an address.
  localparam int RW = ADDR_WIDTH + 1;
  localparam logic [HIST_WIDTH-1:0] MAX_N   = HIST_WIDTH'(MAX_HISTORY);
  localparam logic [HIST_WIDTH-1:0] HIST_1  = HIST_WIDTH'(1);
  localparam logic [RW-1:0]         DEPTH_W = RW'(DEPTH);

  typedef enum logic [1:0] {UNCFG, CALC_DIV, CALC_BASE, RUN} state_t;
  state_t state_reg, state_next;

  logic [HIST_WIDTH-1:0] n_reg, idx_reg, write_slot_reg, frames_done_reg;
  logic [RW-1:0]         region_reg, rem_reg, acc_reg;
  logic [ADDR_WIDTH-1:0] base_reg [MAX_HISTORY];
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  cfg_err_reg, ovf_err_reg;

  logic                  cfg_bad, cfg_load, running;
  logic                  wr_fire, wr_in_range, mem_we;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [HIST_WIDTH-1:0] n_last;
  logic [RW-1:0]         n_ext;

  assign n_last   = n_reg - HIST_1;
  assign n_ext    = RW'(n_reg);
  assign cfg_bad  = (num_of_history_frames == '0) || (num_of_history_frames > MAX_N);
  assign cfg_load = cfg_valid && !cfg_bad;
  assign running  = (state_reg == RUN);

  assign cfg_busy = (state_reg == CALC_DIV) || (state_reg == CALC_BASE);
  assign wr_ready = running;
  assign cfg_err  = cfg_err_reg;
  assign ovf_err  = ovf_err_reg;

  always_ff @(posedge clk) begin
    if (!reset_N) state_reg <= UNCFG;
    else          state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    if (cfg_load) begin
      state_next = CALC_DIV;
    end else begin
      case (state_reg)
        CALC_DIV:  if (rem_reg < n_ext) state_next = CALC_BASE;
        CALC_BASE: if (idx_reg == n_last) state_next = RUN;
        default:   state_next = state_reg;
      endcase
    end
  end

  // Division by repeated subtraction, then base[i] = i*region by accumulation.
  always_ff @(posedge clk) begin
    if (!reset_N) begin
      n_reg           <= '0;
      region_reg      <= '0;
      rem_reg         <= '0;
      acc_reg         <= '0;
      idx_reg         <= '0;
      write_slot_reg  <= '0;
      frames_done_reg <= '0;
      cfg_err_reg     <= 1'b0;
      ovf_err_reg     <= 1'b0;
    end else begin
      cfg_err_reg <= cfg_valid && cfg_bad;
      if (cfg_load) begin
        n_reg           <= num_of_history_frames;
        region_reg      <= '0;
        rem_reg         <= DEPTH_W;
        acc_reg         <= '0;
        idx_reg         <= '0;
        write_slot_reg  <= '0;
        frames_done_reg <= '0;
        ovf_err_reg     <= 1'b0;
      end else begin
        case (state_reg)
          CALC_DIV: begin
            if (rem_reg >= n_ext) begin
              rem_reg    <= rem_reg - n_ext;
              region_reg <= region_reg + RW'(1);
            end
          end
          CALC_BASE: begin
            acc_reg <= acc_reg + region_reg;
            idx_reg <= idx_reg + HIST_1;
          end
          RUN: begin
            if (frame_start) begin
              write_slot_reg <= (write_slot_reg == n_last) ? '0 : write_slot_reg + HIST_1;
              if (frames_done_reg != n_last) frames_done_reg <= frames_done_reg + HIST_1;
            end
            if (wr_fire && !wr_in_range) ovf_err_reg <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state_reg == CALC_BASE) base_reg[idx_reg] <= acc_reg[ADDR_WIDTH-1:0];
  end

  assign wr_fire     = wr_valid && running;
  assign wr_in_range = (RW'(wr_offset) < region_reg);
  assign mem_we      = wr_fire && wr_in_range;
  assign wr_addr     = base_reg[write_slot_reg] + wr_offset;

  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_addr] <= wr_data;
  end

  logic [1:0]                 rd_valid_a;
  logic [1:0][HIST_WIDTH-1:0] rd_age_a;
  logic [1:0][ADDR_WIDTH-1:0] rd_offset_a;

  assign rd_valid_a  = {rd_valid_1, rd_valid_0};
  assign rd_age_a    = {rd_age_1, rd_age_0};
  assign rd_offset_a = {rd_offset_1, rd_offset_0};

  for (genvar gi = 0; gi < 2; gi++) begin : g_rd
    logic [HIST_WIDTH-1:0] slot;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  reject;
    logic [DATA_WIDTH-1:0] data_reg;
    logic                  data_valid_reg, err_reg;

    // Slot arithmetic wraps modulo 2**HIST_WIDTH; the result is only used when age < N.
    always_comb begin
      slot   = (rd_age_a[gi] > write_slot_reg) ? write_slot_reg + n_reg - rd_age_a[gi]
                                               : write_slot_reg - rd_age_a[gi];
      addr   = base_reg[slot] + rd_offset_a[gi];
      reject = !running || (rd_age_a[gi] >= n_reg) || (rd_age_a[gi] > frames_done_reg) ||
               (RW'(rd_offset_a[gi]) >= region_reg);
    end

    always_ff @(posedge clk) begin
      if (!reset_N) begin
        data_reg       <= '0;
        data_valid_reg <= 1'b0;
        err_reg        <= 1'b0;
      end else begin
        data_valid_reg <= rd_valid_a[gi] && !reject;
        err_reg        <= rd_valid_a[gi] && reject;
        if (rd_valid_a[gi] && !reject) begin
`ifdef OFLOW_HIST_BYPASS_EN
          data_reg <= (mem_we && (wr_addr == addr)) ? wr_data : mem[addr];
`else
          data_reg <= mem[addr];
`endif
        end
      end
    end
  end

  assign rd_data_0       = g_rd[0].data_reg;
  assign rd_data_1       = g_rd[1].data_reg;
  assign rd_data_valid_0 = g_rd[0].data_valid_reg;
  assign rd_data_valid_1 = g_rd[1].data_valid_reg;
  assign rd_err_0        = g_rd[0].err_reg;
  assign rd_err_1        = g_rd[1].err_reg;

endmodule

// File: tb/tb_oflow_history_mem_ctrl.sv
// Scoreboard bench for oflow_history_mem_ctrl: directed stimulus pushes expected read responses, a monitor pops them.
`timescale 1ns/1ps
module tb_oflow_history_mem_ctrl;
  localparam int DW = 64, DEPTH = 128, MH = 5, AW = 7, HW = 3;

`ifdef OFLOW_HIST_BYPASS_EN
  localparam logic [DW-1:0] BYP = 64'h55;
`else
  localparam logic [DW-1:0] BYP = 64'h11;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_N, cfg_valid, cfg_busy, cfg_err, frame_start, wr_valid, wr_ready, ovf_err;
  logic [HW-1:0] num_of_history_frames, rd_age_0, rd_age_1;
  logic [AW-1:0] wr_offset, rd_offset_0, rd_offset_1;
  logic [DW-1:0] wr_data, rd_data_0, rd_data_1;
  logic          rd_valid_0, rd_valid_1, rd_data_valid_0, rd_data_valid_1, rd_err_0, rd_err_1;

  oflow_history_mem_ctrl #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .MAX_HISTORY(MH)) dut (
    .clk(clk), .reset_N(reset_N), .cfg_valid(cfg_valid),
    .num_of_history_frames(num_of_history_frames), .cfg_busy(cfg_busy), .cfg_err(cfg_err),
    .frame_start(frame_start), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_offset(wr_offset), .wr_data(wr_data),
    .rd_valid_0(rd_valid_0), .rd_valid_1(rd_valid_1), .rd_age_0(rd_age_0), .rd_age_1(rd_age_1),
    .rd_offset_0(rd_offset_0), .rd_offset_1(rd_offset_1), .rd_data_0(rd_data_0), .rd_data_1(rd_data_1),
    .rd_data_valid_0(rd_data_valid_0), .rd_data_valid_1(rd_data_valid_1),
    .rd_err_0(rd_err_0), .rd_err_1(rd_err_1), .ovf_err(ovf_err)
  );

  typedef struct { int cyc; bit err; logic [DW-1:0] data; } exp_t;
  exp_t q0[$];
  exp_t q1[$];
  int checks = 0, errors = 0, cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: any response must match the oldest outstanding request of that port, one cycle later.
  task automatic mon(input int p, input logic dv, input logic er, input logic [DW-1:0] d);
    exp_t e;
    if (dv === 1'b1 || er === 1'b1) begin
      if ((p == 0 && q0.size() == 0) || (p == 1 && q1.size() == 0)) begin
        checks++;
        errors++;
        $display("FAIL rd%0d_unexpected: got dv=%b err=%b expected no response", p, dv, er);
      end else begin
        if (p == 0) e = q0.pop_front();
        else        e = q1.pop_front();
        $display("rd%0d cyc=%0d dv=%b err=%b data=0x%0h", p, cyc, dv, er, d);
        check_int($sformatf("rd%0d_latency", p), cyc, e.cyc + 1);
        check_bit($sformatf("rd%0d_err", p), er, e.err);
        check_bit($sformatf("rd%0d_valid", p), dv, !e.err);
        if (!e.err) check_val($sformatf("rd%0d_data", p), d, e.data);
      end
    end
  endtask

  initial forever begin
    @(negedge clk);
    mon(0, rd_data_valid_0, rd_err_0, rd_data_0);
    mon(1, rd_data_valid_1, rd_err_1, rd_data_1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cfg_valid = 1'b0; frame_start = 1'b0; wr_valid = 1'b0;
    rd_valid_0 = 1'b0; rd_valid_1 = 1'b0;
  endtask

  task automatic step();
    tick();
    idle();
  endtask

  task automatic drive_rd(input int p, input logic [HW-1:0] age, input logic [AW-1:0] off,
                          input bit err, input logic [DW-1:0] data);
    exp_t e;
    e.cyc = cyc; e.err = err; e.data = data;
    if (p == 0) begin
      rd_valid_0 = 1'b1; rd_age_0 = age; rd_offset_0 = off; q0.push_back(e);
    end else begin
      rd_valid_1 = 1'b1; rd_age_1 = age; rd_offset_1 = off; q1.push_back(e);
    end
  endtask

  task automatic read1(input int p, input logic [HW-1:0] age, input logic [AW-1:0] off,
                       input bit err, input logic [DW-1:0] data);
    drive_rd(p, age, off, err, data);
    step();
  endtask

  task automatic do_write(input logic [AW-1:0] off, input logic [DW-1:0] data);
    wr_valid = 1'b1; wr_offset = off; wr_data = data;
    $display("wr off=%0d data=0x%0h", off, data);
    step();
  endtask

  task automatic do_frame();
    frame_start = 1'b1;
    step();
  endtask

  task automatic configure(input logic [HW-1:0] n, input int exp_busy, input string name);
    int cnt;
    cfg_valid = 1'b1; num_of_history_frames = n;
    step();
    cnt = 0;
    while (cfg_busy === 1'b1 && cnt < 1000) begin
      cnt++;
      tick();
    end
    $display("cfg n=%0d busy_cycles=%0d", n, cnt);
    check_int(name, cnt, exp_busy);
    check_bit({name, "_wr_ready"}, wr_ready, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    idle();
    reset_N = 1'b0; num_of_history_frames = '0;
    rd_age_0 = '0; rd_age_1 = '0; rd_offset_0 = '0; rd_offset_1 = '0;
    wr_offset = '0; wr_data = '0;
    repeat (3) tick();
    check_bit("rst_cfg_busy", cfg_busy, 1'b0);
    check_bit("rst_cfg_err", cfg_err, 1'b0);
    check_bit("rst_wr_ready", wr_ready, 1'b0);
    check_bit("rst_ovf_err", ovf_err, 1'b0);
    check_bit("rst_rd_dv0", rd_data_valid_0, 1'b0);
    check_bit("rst_rd_err1", rd_err_1, 1'b0);
    check_val("rst_rd_data0", rd_data_0, '0);
    check_val("rst_rd_data1", rd_data_1, '0);
    reset_N = 1'b1;
    tick();

    read1(0, 3'd0, 7'd0, 1'b1, '0);              // unconfigured: rejected

    configure(3'd5, 31, "busy_n5");
    for (int i = 0; i < 5; i++)
      check_val($sformatf("base_%0d", i), 64'(dut.base_reg[i]), 64'(i * 25));

    for (int f = 0; f < 6; f++) begin
      do_write(7'd3, 64'('hA0 + f));
      if (f < 5) do_frame();
    end
    for (int a = 0; a < 5; a++) begin
      drive_rd(0, HW'(a), 7'd3, 1'b0, 64'('hA5 - a));
      drive_rd(1, HW'(4 - a), 7'd3, 1'b0, 64'('hA1 + a));
      step();
    end
    drive_rd(0, 3'd5, 7'd3, 1'b1, '0);
    drive_rd(1, 3'd5, 7'd3, 1'b1, '0);
    step();

    // One frame of history only: age 2 is rejected, age 1 is readable.
    configure(3'd5, 31, "busy_n5_again");
    do_write(7'd7, 64'h66);
    do_frame();
    do_write(7'd7, 64'h77);
    read1(0, 3'd2, 7'd7, 1'b1, '0);
    read1(0, 3'd1, 7'd7, 1'b0, 64'h66);
    read1(1, 3'd0, 7'd7, 1'b0, 64'h77);
    read1(1, 3'd0, 7'd25, 1'b1, '0);

    // N=4, region 32: offset 32 is out of range; address 32 keeps 0x77.
    configure(3'd4, 37, "busy_n4");
    do_write(7'd31, 64'h31);
    check_bit("ovf_before", ovf_err, 1'b0);
    do_write(7'd32, 64'hBAD);
    check_bit("ovf_set", ovf_err, 1'b1);
    do_frame();
    read1(0, 3'd0, 7'd0, 1'b0, 64'h77);
    read1(0, 3'd1, 7'd31, 1'b0, 64'h31);
    read1(1, 3'd0, 7'd32, 1'b1, '0);
    check_bit("ovf_sticky", ovf_err, 1'b1);

    // Same-cycle write and dual read of one address.
    do_write(7'd5, 64'h11);
    wr_valid = 1'b1; wr_offset = 7'd5; wr_data = 64'h55;
    drive_rd(0, 3'd0, 7'd5, 1'b0, BYP);
    drive_rd(1, 3'd0, 7'd5, 1'b0, BYP);
    step();
    read1(0, 3'd0, 7'd5, 1'b0, 64'h55);

    // Write in the frame_start cycle lands in the old slot.
    wr_valid = 1'b1; wr_offset = 7'd9; wr_data = 64'h99; frame_start = 1'b1;
    step();
    read1(0, 3'd1, 7'd9, 1'b0, 64'h99);

    cfg_valid = 1'b1; num_of_history_frames = 3'd0;
    step();
    check_bit("cfg_err_n0", cfg_err, 1'b1);
    check_bit("cfg_n0_stays_run", wr_ready, 1'b1);
    check_bit("cfg_n0_not_busy", cfg_busy, 1'b0);
    tick();
    check_bit("cfg_err_pulse_end", cfg_err, 1'b0);
    cfg_valid = 1'b1; num_of_history_frames = 3'd6;
    step();
    check_bit("cfg_err_n6", cfg_err, 1'b1);

    // Restart in CALC_DIV with N=3: region 42.
    cfg_valid = 1'b1; num_of_history_frames = 3'd5;
    step();
    repeat (5) tick();
    check_bit("busy_mid_div", cfg_busy, 1'b1);
    configure(3'd3, 46, "busy_restart_n3");
    check_bit("ovf_cleared", ovf_err, 1'b0);
    read1(0, 3'd1, 7'd0, 1'b1, '0);
    read1(0, 3'd0, 7'd42, 1'b1, '0);
    do_write(7'd41, 64'h42);
    read1(1, 3'd0, 7'd41, 1'b0, 64'h42);

    repeat (3) tick();
    check_int("q0_drained", q0.size(), 0);
    check_int("q1_drained", q1.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
